// File: rtl/lcd_video_timing_src.sv
// lcd_video_timing_src: LCD timing generator that pulls RGB565 pixels from a latency-1 FIFO
module lcd_video_timing_src #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_data,
    input  logic        i_empty,
    output logic        o_rd_req,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [15:0] o_data,
    output logic        o_frame_start,
    output logic        o_underflow
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ST    = H_SYNC + H_BP;
    localparam int V_ST    = V_SYNC + V_BP;

    logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic        h_wrap, act, nxt_act, origin, starved, set_uf;

    function automatic logic in_rng(input logic [11:0] c, input int lo, input int n);
        return int'(c) >= lo && int'(c) < lo + n;
    endfunction

    // next counter position and region decodes for the current and next position
    always_comb begin
        h_wrap  = h_cnt == 12'(H_TOTAL - 1);
        h_nxt   = h_wrap ? 12'd0 : h_cnt + 12'd1;
        v_nxt   = !h_wrap ? v_cnt : (v_cnt == 12'(V_TOTAL - 1) ? 12'd0 : v_cnt + 12'd1);
        act     = in_rng(h_cnt, H_ST, H_ACTIVE) && in_rng(v_cnt, V_ST, V_ACTIVE);
        nxt_act = in_rng(h_nxt, H_ST, H_ACTIVE) && in_rng(v_nxt, V_ST, V_ACTIVE);
        origin  = h_cnt == 12'd0 && v_cnt == 12'd0;
        set_uf  = o_rd_req && i_empty;
    end

    // counters plus outputs registered one clock behind them; read request looks one position ahead
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_hs          <= ~HS_POL;
            o_vs          <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_rd_req      <= 1'b0;
            starved       <= 1'b0;
            o_underflow   <= 1'b0;
        end else begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            o_hs          <= in_rng(h_cnt, 0, H_SYNC) ? HS_POL : ~HS_POL;
            o_vs          <= in_rng(v_cnt, 0, V_SYNC) ? VS_POL : ~VS_POL;
            o_de          <= act;
            o_x           <= act ? h_cnt - 12'(H_ST) : 12'd0;
            o_y           <= act ? v_cnt - 12'(V_ST) : 12'd0;
            o_frame_start <= origin;
            o_rd_req      <= nxt_act;
            starved       <= set_uf;
            o_underflow   <= set_uf || (o_underflow && !origin);
        end
    end

    assign o_data = (o_de && !starved) ? i_data : 16'h0000;
endmodule
